// File: rtl/counter_pkg.sv
// counter_pkg: shared types and reset constants for the counter bank.
//   cnt_mode_e  - terminal behaviour of a channel (wrap / saturate / one-shot)
//   RST_*       - values every channel returns to on reset
//   cfg_valid   - helper that screens a config write for illegal content
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2,
        CNT_RSVD    = 2'd3
    } cnt_mode_e;

    // Reset window is the full range; the bound registers are WIDTH-generic,
    // so they are expressed as one replicated bit.
    localparam logic      RST_MIN_BIT = 1'b0;
    localparam logic      RST_MAX_BIT = 1'b1;
    localparam cnt_mode_e RST_MODE    = CNT_WRAP;
    localparam logic      RST_UP      = 1'b1;

    // Content check only (window ordering and mode); channel range is
    // checked by the top level since it depends on NUM_CH.
    function automatic logic cfg_valid(input logic min_gt_max, input logic [1:0] mode);
        return !min_gt_max && (mode != CNT_RSVD);
    endfunction

endpackage

// File: rtl/counter_channel.sv
// counter_channel: one bounded up/down counter with its own config.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   cfg_hit          - accepted config write aimed at this channel
//   cfg_min/max/mode/up - config payload (already validated upstream)
//   clr, load        - synchronous restart / load (load_val clamped)
//   load_val         - shared load value
//   cnten            - count enable
//   cnt              - current count
//   tc               - one-cycle terminal-count pulse (registered)
//   done             - one-shot completion flag (level)
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_hit,
    input  logic [WIDTH-1:0] cfg_min,
    input  logic [WIDTH-1:0] cfg_max,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             cnten,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             done
);

    typedef struct packed {
        logic [WIDTH-1:0] min;
        logic [WIDTH-1:0] max;
        cnt_mode_e        mode;
        logic             up;
    } ch_cfg_t;

    ch_cfg_t          cfg;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] load_clamped;

    // Up counters start at min and terminate at max; down counters the reverse.
    assign start_val = cfg.up ? cfg.min : cfg.max;
    assign term_val  = cfg.up ? cfg.max : cfg.min;

    assign load_clamped = (load_val < cfg.min) ? cfg.min :
                          (load_val > cfg.max) ? cfg.max : load_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg.min  <= {WIDTH{RST_MIN_BIT}};
            cfg.max  <= {WIDTH{RST_MAX_BIT}};
            cfg.mode <= RST_MODE;
            cfg.up   <= RST_UP;
            cnt      <= '0;
            tc       <= 1'b0;
            done     <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (cfg_hit) begin
                cfg.min  <= cfg_min;
                cfg.max  <= cfg_max;
                cfg.mode <= cnt_mode_e'(cfg_mode);
                cfg.up   <= cfg_up;
                cnt      <= cfg_up ? cfg_min : cfg_max;
                done     <= 1'b0;
            end else if (clr) begin
                cnt  <= start_val;
                done <= 1'b0;
            end else if (load) begin
                cnt  <= load_clamped;
                done <= 1'b0;
            end else if (cnten && !done) begin
                if (cnt != term_val) begin
                    cnt <= cfg.up ? cnt + 1'b1 : cnt - 1'b1;
                end else begin
                    // Terminal step; min==max lands here on every enabled cycle.
                    case (cfg.mode)
                        CNT_WRAP: begin
                            cnt <= start_val;
                            tc  <= 1'b1;
                        end
                        CNT_SAT: begin
                            tc <= 1'b1;
                        end
                        CNT_ONESHOT: begin
                            done <= 1'b1;
                            tc   <= 1'b1;
                        end
                        default: begin
                            // Reserved mode is never latched; hold.
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/counter_bank.sv
// counter_bank: NUM_CH independent bounded up/down counters.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   cfg_we, cfg_sel            - config write strobe and target channel
//   cfg_min, cfg_max           - window bounds
//   cfg_mode, cfg_up           - terminal mode and direction
//   cfg_err                    - registered pulse: last config write rejected
//   clr, load, cnten           - per-channel run-time controls
//   load_val                   - shared load value
//   cnt_value                  - packed counts, channel i at [i*WIDTH +: WIDTH]
//   tc, done                   - per-channel terminal pulse / one-shot done
module counter_bank
    import counter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [SEL_W-1:0]        cfg_sel,
    input  logic [WIDTH-1:0]        cfg_min,
    input  logic [WIDTH-1:0]        cfg_max,
    input  logic [1:0]              cfg_mode,
    input  logic                    cfg_up,
    output logic                    cfg_err,
    input  logic [NUM_CH-1:0]       clr,
    input  logic [NUM_CH-1:0]       load,
    input  logic [WIDTH-1:0]        load_val,
    input  logic [NUM_CH-1:0]       cnten,
    output logic [NUM_CH*WIDTH-1:0] cnt_value,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       done
);

    logic sel_ok;
    logic cfg_ok;

    assign sel_ok = 32'(cfg_sel) < 32'(NUM_CH);
    assign cfg_ok = cfg_we && sel_ok && cfg_valid(cfg_min > cfg_max, cfg_mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        counter_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .cfg_hit  (cfg_ok && (cfg_sel == SEL_W'(i))),
            .cfg_min  (cfg_min),
            .cfg_max  (cfg_max),
            .cfg_mode (cfg_mode),
            .cfg_up   (cfg_up),
            .clr      (clr[i]),
            .load     (load[i]),
            .load_val (load_val),
            .cnten    (cnten[i]),
            .cnt      (cnt_value[i*WIDTH +: WIDTH]),
            .tc       (tc[i]),
            .done     (done[i])
        );
    end

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank (NUM_CH=4, WIDTH=32).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_counter_bank;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 32;
    localparam int SEL_W  = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    cfg_we;
    logic [SEL_W-1:0]        cfg_sel;
    logic [WIDTH-1:0]        cfg_min;
    logic [WIDTH-1:0]        cfg_max;
    logic [1:0]              cfg_mode;
    logic                    cfg_up;
    logic                    cfg_err;
    logic [NUM_CH-1:0]       clr;
    logic [NUM_CH-1:0]       load;
    logic [WIDTH-1:0]        load_val;
    logic [NUM_CH-1:0]       cnten;
    logic [NUM_CH*WIDTH-1:0] cnt_value;
    logic [NUM_CH-1:0]       tc;
    logic [NUM_CH-1:0]       done;

    int checks = 0;
    int errors = 0;

    counter_bank #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .SEL_W  (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_min   (cfg_min),
        .cfg_max   (cfg_max),
        .cfg_mode  (cfg_mode),
        .cfg_up    (cfg_up),
        .cfg_err   (cfg_err),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .cnten     (cnten),
        .cnt_value (cnt_value),
        .tc        (tc),
        .done      (done)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [NUM_CH*WIDTH-1:0] obs,
                         input logic [NUM_CH*WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ch(input int i);
        return cnt_value[i*WIDTH +: WIDTH];
    endfunction

    task automatic cfg_write(input int sel, input int mn, input int mx,
                             input int mode, input logic up);
        cfg_we   = 1'b1;
        cfg_sel  = SEL_W'(sel);
        cfg_min  = WIDTH'(mn);
        cfg_max  = WIDTH'(mx);
        cfg_mode = 2'(mode);
        cfg_up   = up;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_min = '0; cfg_max = '0;
        cfg_mode = '0; cfg_up = 1'b0; clr = '0; load = '0; load_val = '0; cnten = '0;

        // reset state
        #12;
        check("rst_cnt", cnt_value, '0);
        check("rst_tc", {124'd0, tc}, '0);
        check("rst_done", {124'd0, done}, '0);
        check("rst_err", {127'd0, cfg_err}, '0);
        rst_n = 1'b1;
        step();

        // ch0 default window, three enabled steps
        cnten = 4'b0001;
        step(); step(); step();
        check("ch0_cnt3", ch(0), 3);
        check("ch0_tc", {124'd0, tc}, '0);
        check("ch0_done", {124'd0, done}, '0);
        check("ch0_err", {127'd0, cfg_err}, '0);
        cnten = '0;

        // ch1 WRAP up [5,7]
        cfg_write(1, 5, 7, 0, 1'b1);
        step();
        cfg_we = 1'b0;
        check("ch1_start", ch(1), 5);
        cnten = 4'b0010;
        step(); check("ch1_s1", ch(1), 6); check("ch1_s1_tc", {124'd0, tc}, '0);
        step(); check("ch1_s2", ch(1), 7); check("ch1_s2_tc", {124'd0, tc}, '0);
        step(); check("ch1_wrap", ch(1), 5); check("ch1_wrap_tc", {124'd0, tc}, 4'b0010);
        step(); check("ch1_s4", ch(1), 6); check("ch1_s4_tc", {124'd0, tc}, '0);
        cnten = '0;

        // ch2 ONESHOT down [10,12]
        cfg_write(2, 10, 12, 2, 1'b0);
        step();
        cfg_we = 1'b0;
        check("ch2_start", ch(2), 12);
        cnten = 4'b0100;
        step(); check("ch2_s1", ch(2), 11);
        step(); check("ch2_s2", ch(2), 10); check("ch2_s2_done", {124'd0, done}, '0);
        step(); check("ch2_term", ch(2), 10);
        check("ch2_term_tc", {124'd0, tc}, 4'b0100);
        check("ch2_term_done", {124'd0, done}, 4'b0100);
        step(); check("ch2_s4", ch(2), 10); check("ch2_s4_tc", {124'd0, tc}, '0);
        step(); check("ch2_s5_done", {124'd0, done}, 4'b0100);
        cnten = '0; clr = 4'b0100;
        step();
        clr = '0;
        check("ch2_clr", ch(2), 12); check("ch2_clr_done", {124'd0, done}, '0);

        // ch3 SAT up [0,3], load clamps 9 -> 3
        cfg_write(3, 0, 3, 1, 1'b1);
        step();
        cfg_we = 1'b0;
        check("ch3_start", ch(3), 0);
        load = 4'b1000; load_val = 9;
        step();
        load = '0;
        check("ch3_load", ch(3), 3);
        cnten = 4'b1000;
        step(); check("ch3_sat1", ch(3), 3); check("ch3_sat1_tc", {124'd0, tc}, 4'b1000);
        step(); check("ch3_sat2", ch(3), 3); check("ch3_sat2_tc", {124'd0, tc}, 4'b1000);
        cnten = '0;
        step(); check("ch3_idle_tc", {124'd0, tc}, '0);

        // rejected writes: min>max, then reserved mode
        cfg_write(3, 8, 4, 0, 1'b1);
        step();
        cfg_we = 1'b0;
        check("err_minmax", {127'd0, cfg_err}, 1);
        check("err_minmax_cnt", ch(3), 3);
        step();
        check("err_clear", {127'd0, cfg_err}, 0);
        cfg_write(3, 0, 1, 3, 1'b0);
        step();
        cfg_we = 1'b0;
        check("err_rsvd", {127'd0, cfg_err}, 1);
        check("err_rsvd_cnt", ch(3), 3);
        cnten = 4'b1000;
        step();
        cnten = '0;
        check("err_keep_sat", ch(3), 3);
        check("err_keep_tc", {124'd0, tc}, 4'b1000);
        check("err_clear2", {127'd0, cfg_err}, 0);

        // cfg beats clr and load on ch0; ch1 steps independently (6 -> 7)
        cfg_write(0, 20, 30, 0, 1'b0);
        clr = 4'b0001; load = 4'b0001; load_val = 25; cnten = 4'b0010;
        step();
        cfg_we = 1'b0; clr = '0; load = '0; cnten = '0;
        check("prio_cfg_ch0", ch(0), 30);
        check("prio_ch1", ch(1), 7);
        cnten = 4'b0001;
        step();
        cnten = '0;
        check("ch0_down", ch(0), 29);

        // asynchronous reset mid-run, no edge in between
        cnten = 4'b1111;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_cnt", cnt_value, '0);
        check("arst_tc", {124'd0, tc}, '0);
        check("arst_done", {124'd0, done}, '0);
        check("arst_err", {127'd0, cfg_err}, '0);
        cnten = '0;
        step();
        rst_n = 1'b1;
        cnten = 4'b0010;
        step();
        cnten = '0;
        check("arst_window", ch(1), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
